// File: rtl/uart_pkg.sv
// Shared UART receive types and defaults: FSM states, parity selectors, frame geometry.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PRESCALE   = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser, bit-period counter and bit sampler with a decision strobe.
// Define UART_RX_MAJORITY_EN to use a 3-sample majority vote instead of a single mid-bit sample.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  input  logic i_en,
  output logic o_rx_s,
  output logic o_bit,
  output logic o_bit_done,
  output logic o_period_end
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SMP_LO  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP_MID = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SMP_DEC = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic          r_sync1;
  logic          r_rx_s;
  logic [CW-1:0] r_edge_cnt;
  logic          r_smp_mid;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_edge_cnt <= '0;
      r_smp_mid  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_rx_s  <= r_sync1;
      if (!i_en || (r_edge_cnt == CNT_MAX)) begin
        r_edge_cnt <= '0;
      end else begin
        r_edge_cnt <= r_edge_cnt + CW'(1);
      end
      if (r_edge_cnt == SMP_MID) begin
        r_smp_mid <= r_rx_s;
      end
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_lo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_smp_lo <= 1'b1;
    end else if (r_edge_cnt == SMP_LO) begin
      r_smp_lo <= r_rx_s;
    end
  end

  // Third vote is the live sample at the decision point itself.
  assign o_bit = (r_smp_lo & r_smp_mid) | (r_smp_lo & r_rx_s) | (r_smp_mid & r_rx_s);
`else
  assign o_bit = r_smp_mid;
`endif

  assign o_rx_s       = r_rx_s;
  assign o_bit_done   = (r_edge_cnt == SMP_DEC);
  assign o_period_end = (r_edge_cnt == CNT_MAX);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start detect, LSB-first deserialise, parity/stop check, valid pulse.
// Optional build macro UART_RX_MAJORITY_EN selects majority-vote bit sampling in the sampler.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PRESCALE   = DEF_PRESCALE
) (
  input  logic                  CLK,
  input  logic                  Parity_Calc_RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  rx_state_e             r_state, w_state_d;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_d;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [DATA_WIDTH-1:0] r_p_data, w_p_data_d;
  logic                  r_par_en, w_par_en_d;
  logic                  r_par_typ, w_par_typ_d;
  logic                  r_par_flag, w_par_flag_d;
  logic                  r_valid, w_valid_d;
  logic                  r_par_err, w_par_err_d;
  logic                  r_stp_err, w_stp_err_d;

  logic w_rx_s;
  logic w_bit;
  logic w_bit_done;
  logic w_period_end;
  logic w_cnt_en;
  logic w_par_exp;

  uart_rx_sampler #(
    .PRESCALE (PRESCALE)
  ) u_sampler (
    .i_clk        (CLK),
    .i_rst_n      (Parity_Calc_RST),
    .i_rx         (RX_IN),
    .i_en         (w_cnt_en),
    .o_rx_s       (w_rx_s),
    .o_bit        (w_bit),
    .o_bit_done   (w_bit_done),
    .o_period_end (w_period_end)
  );

  assign w_par_exp = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;

  always_ff @(posedge CLK or negedge Parity_Calc_RST) begin
    if (!Parity_Calc_RST) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_p_data   <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_flag <= 1'b0;
      r_valid    <= 1'b0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_p_data   <= w_p_data_d;
      r_par_en   <= w_par_en_d;
      r_par_typ  <= w_par_typ_d;
      r_par_flag <= w_par_flag_d;
      r_valid    <= w_valid_d;
      r_par_err  <= w_par_err_d;
      r_stp_err  <= w_stp_err_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_p_data_d   = r_p_data;
    w_par_en_d   = r_par_en;
    w_par_typ_d  = r_par_typ;
    w_par_flag_d = r_par_flag;
    w_valid_d    = 1'b0;
    w_par_err_d  = 1'b0;
    w_stp_err_d  = 1'b0;
    w_cnt_en     = 1'b1;
    unique case (r_state)
      IDLE: begin
        // The detect cycle is edge_cnt 0, keeping the counter aligned to the rx_s bit cell.
        w_cnt_en = ~w_rx_s;
        if (!w_rx_s) begin
          w_state_d    = START;
          w_par_en_d   = PAR_EN;
          w_par_typ_d  = PAR_TYP;
          w_par_flag_d = 1'b0;
          w_bit_cnt_d  = '0;
        end
      end
      START: begin
        if (w_bit_done && w_bit) begin
          w_state_d = IDLE;
          w_cnt_en  = 1'b0;
        end else if (w_period_end) begin
          w_state_d = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_d = {w_bit, r_shift[DATA_WIDTH-1:1]};
        end
        if (w_period_end) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_d = '0;
            w_state_d   = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_cnt_d = r_bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_par_flag_d = (w_bit != w_par_exp);
        end
        if (w_period_end) begin
          w_state_d = STOP;
        end
      end
      STOP: begin
        // Leave early so a start edge right after the stop sample is caught.
        if (w_bit_done) begin
          w_state_d = IDLE;
          w_cnt_en  = 1'b0;
          if (!w_bit) begin
            w_stp_err_d = 1'b1;
          end else if (r_par_flag) begin
            w_par_err_d = 1'b1;
          end else begin
            w_valid_d  = 1'b1;
            w_p_data_d = r_shift;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  assign P_DATA     = r_p_data;
  assign Data_Valid = r_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;

endmodule
